// File: rtl/dht11_responder_if.sv
// Data and status bundle for the DHT11 sensor emulator. The sensor core uses the
// slave modport; the host side uses the master modport.
interface dht11_responder_if;
  logic [7:0]  hum_int;
  logic [7:0]  hum_float;
  logic [7:0]  tmp_int;
  logic [7:0]  tmp_float;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  modport master (
    output hum_int, hum_float, tmp_int, tmp_float,
    input  busy, frame_done, frame_count
  );

  modport slave (
    input  hum_int, hum_float, tmp_int, tmp_float,
    output busy, frame_done, frame_count
  );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator on an open-drain line: detects the host start pulse and answers
// with the preamble plus a 40-bit frame. DHT11_RESPONDER_COOLDOWN_EN adds a post-frame lockout.
module dht11_responder #(
  parameter int unsigned T_START_MIN = 1800000,
  parameter int unsigned T_WAIT      = 3000,
  parameter int unsigned T_RESP_LOW  = 8000,
  parameter int unsigned T_RESP_HIGH = 8000,
  parameter int unsigned T_BIT_LOW   = 5000,
  parameter int unsigned T_BIT0_HIGH = 2700,
  parameter int unsigned T_BIT1_HIGH = 7000,
  parameter int unsigned T_COOLDOWN  = 100000000
) (
  input  logic             CLK,
  input  logic             RST,
  inout  wire              DHT_data,
  dht11_responder_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRlow,
    StRhigh,
    StBlow,
    StBhigh,
    StElow
`ifdef DHT11_RESPONDER_COOLDOWN_EN
    , StCool
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] low_cnt_q, low_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] limit;
  logic        phase_end;
  logic [7:0]  csum;

  // Registered drive: async reset releases the line without waiting for a clock.
  assign DHT_data = drive_q ? 1'b0 : 1'bz;

  assign csum = bus.hum_int + bus.hum_float + bus.tmp_int + bus.tmp_float;

  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = frame_cnt_q;

  always_comb begin
    unique case (state_q)
      StWait:  limit = T_WAIT;
      StRlow:  limit = T_RESP_LOW;
      StRhigh: limit = T_RESP_HIGH;
      StBlow:  limit = T_BIT_LOW;
      StBhigh: limit = shift_q[39] ? T_BIT1_HIGH : T_BIT0_HIGH;
      StElow:  limit = T_BIT_LOW;
      default: limit = T_COOLDOWN;
    endcase
  end

  assign phase_end = (cnt_q >= limit - 32'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    low_cnt_d   = '0;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!sync2_q) begin
          low_cnt_d = (low_cnt_q >= T_START_MIN) ? low_cnt_q : low_cnt_q + 32'd1;
        end else if (!prev_q && low_cnt_q >= T_START_MIN) begin
          shift_d   = {bus.hum_int, bus.hum_float, bus.tmp_int, bus.tmp_float, csum};
          bit_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = StWait;
        end
      end
      StWait:  if (phase_end) state_d = StRlow;
      StRlow:  if (phase_end) state_d = StRhigh;
      StRhigh: if (phase_end) state_d = StBlow;
      StBlow:  if (phase_end) state_d = StBhigh;
      StBhigh: begin
        if (phase_end) begin
          shift_d   = {shift_q[38:0], 1'b0};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'd39) ? StElow : StBlow;
        end
      end
      StElow: begin
        if (phase_end) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          busy_d      = 1'b0;
`ifdef DHT11_RESPONDER_COOLDOWN_EN
          state_d     = StCool;
`else
          state_d     = StIdle;
`endif
        end
      end
`ifdef DHT11_RESPONDER_COOLDOWN_EN
      StCool:  if (phase_end) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = '0;
    drive_d = (state_d == StRlow) || (state_d == StBlow) || (state_d == StElow);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      low_cnt_q   <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      low_cnt_q   <= low_cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      sync1_q     <= DHT_data;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder with scaled timing: a host emulator drives start pulses and a
// line decoder measures every phase against a frame model built from the data bytes.
module tb_dht11_responder;

  localparam int unsigned T_START_MIN = 180;
  localparam int unsigned T_WAIT      = 30;
  localparam int unsigned T_RESP_LOW  = 80;
  localparam int unsigned T_RESP_HIGH = 80;
  localparam int unsigned T_BIT_LOW   = 50;
  localparam int unsigned T_BIT0_HIGH = 27;
  localparam int unsigned T_BIT1_HIGH = 70;
  localparam int unsigned T_COOLDOWN  = 2000;
  localparam int          LIMIT       = 20000;

  logic clk;
  logic rst;
  logic host_low;
  wire  dht_line;
  int   n_pass;
  int   n_fail;
  int   n_total;

  pullup (dht_line);
  assign dht_line = host_low ? 1'b0 : 1'bz;

  dht11_responder_if bus ();

  dht11_responder #(
    .T_START_MIN (T_START_MIN),
    .T_WAIT      (T_WAIT),
    .T_RESP_LOW  (T_RESP_LOW),
    .T_RESP_HIGH (T_RESP_HIGH),
    .T_BIT_LOW   (T_BIT_LOW),
    .T_BIT0_HIGH (T_BIT0_HIGH),
    .T_BIT1_HIGH (T_BIT1_HIGH),
    .T_COOLDOWN  (T_COOLDOWN)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .DHT_data (dht_line),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as the sensor should send it: four bytes then their sum mod 256.
  function automatic logic [39:0] model(input logic [7:0] h, input logic [7:0] hf,
                                        input logic [7:0] t, input logic [7:0] tf);
    int s;
    logic [7:0] c;
    s = (int'(h) + int'(hf) + int'(t) + int'(tf)) % 256;
    c = s[7:0];
    return {h, hf, t, tf, c};
  endfunction

  task automatic set_bytes(input logic [7:0] h, input logic [7:0] hf,
                           input logic [7:0] t, input logic [7:0] tf);
    bus.hum_int   = h;
    bus.hum_float = hf;
    bus.tmp_int   = t;
    bus.tmp_float = tf;
  endtask

  task automatic host_req(input int n);
    host_low = 1'b1;
    repeat (n) step();
    host_low = 1'b0;
  endtask

  task automatic gap();
`ifdef DHT11_RESPONDER_COOLDOWN_EN
    repeat (T_COOLDOWN + 10) step();
`else
    repeat (10) step();
`endif
  endtask

  task automatic run_level(input logic lvl, output int n);
    n = 0;
    while (dht_line === lvl && n < LIMIT) begin
      n++;
      step();
    end
  endtask

  // Decode one response right after the host release; optionally swap hum_int mid-frame
  // or assert reset at the start of a bit's low phase.
  task automatic do_frame(input logic [39:0] exp, input int chg_bit,
                          input logic [7:0] chg_val, input int abort_bit);
    int n;
    logic [39:0] got;
    int half;
    half = int'(T_BIT0_HIGH + T_BIT1_HIGH) / 2;
    got  = '0;
    step();
    n = 0;
    while (dht_line !== 1'b0 && n < LIMIT) begin
      step();
      n++;
    end
    check("wait_latency", n, 2 + T_WAIT);
    check("busy_in_frame", bus.busy, 1);
    run_level(1'b0, n);
    check("resp_low", n, T_RESP_LOW);
    run_level(1'b1, n);
    check("resp_high", n, T_RESP_HIGH);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_bit) begin
        #2 rst = 1'b1;
        #1;
        check("rst_line_release", dht_line, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.frame_count, 0);
        return;
      end
      if (i == chg_bit) bus.hum_int = chg_val;
      run_level(1'b0, n);
      check("bit_low", n, T_BIT_LOW);
      run_level(1'b1, n);
      got = {got[38:0], n > half};
      check("bit_high", n, exp[39-i] ? T_BIT1_HIGH : T_BIT0_HIGH);
    end
    run_level(1'b0, n);
    check("end_low", n, T_BIT_LOW);
    check("done_pulse", bus.frame_done, 1);
    check("frame_bits", got, exp);
    step();
    check("done_single", bus.frame_done, 0);
    check("busy_clear", bus.busy, 0);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      step();
      if (dht_line !== 1'b1 || bus.busy !== 1'b0) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [39:0] exp;
    logic [7:0]  r0, r1, r2, r3;
    n_pass   = 0;
    n_fail   = 0;
    n_total  = 0;
    rst      = 1'b1;
    host_low = 1'b0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) step();
    check("reset_line", dht_line, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.frame_done, 0);
    check("reset_count", bus.frame_count, 0);
    rst = 1'b0;
    repeat (5) step();

    // Nominal frame
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    exp = model(8'h37, 8'h00, 8'h19, 8'h05);
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, -1);
    check("count_1", bus.frame_count, 1);
    gap();

    // Start pulse just short of the minimum
    host_req(T_START_MIN - 10);
    expect_silence("short_ignored", T_WAIT + 200);
    check("count_after_short", bus.frame_count, 1);
    gap();

    // All ones
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    exp = model(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, -1);
    gap();

    // Random byte sets
    for (int k = 0; k < 3; k++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      set_bytes(r0, r1, r2, r3);
      exp = model(r0, r1, r2, r3);
      host_req(T_START_MIN);
      do_frame(exp, -1, 8'h00, -1);
      gap();
    end
    check("count_5", bus.frame_count, 5);

    // Input change during bit 3 must not reach the frame in flight
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    exp = model(8'h37, 8'h00, 8'h19, 8'h05);
    host_req(T_START_MIN);
    do_frame(exp, 3, 8'h50, -1);
    gap();

    // Reset during bit 20, then a complete frame
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    exp = model(8'h12, 8'h34, 8'h56, 8'h78);
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, 20);
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, -1);
    check("count_after_rst", bus.frame_count, 1);

`ifdef DHT11_RESPONDER_COOLDOWN_EN
    // Request inside the lockout is ignored; one after it is answered
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    r0 = 8'($urandom);
    set_bytes(r0, 8'h01, 8'h02, 8'h03);
    exp = model(r0, 8'h01, 8'h02, 8'h03);
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, -1);
    repeat (T_COOLDOWN / 2) step();
    host_req(T_START_MIN);
    expect_silence("cooldown_ignored", 300);
    check("cooldown_count_1", bus.frame_count, 1);
    repeat (T_COOLDOWN / 2 - 100) step();
    host_req(T_START_MIN);
    do_frame(exp, -1, 8'h00, -1);
    check("cooldown_count_2", bus.frame_count, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
